min_feeder: RTL and testbench



---
 rtl/min_feeder_if.sv | 29 ++
 rtl/min_feeder.sv | 112 +++++++++++
 tb/tb_min_feeder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_feeder_if.sv
// Bundle of the score-input, min-search and result ports of min_feeder.
// Valid/ready rule for in_* and out_*: a word moves on a rising edge where valid && ready;
// the source holds valid and data stable until then, and ready may depend on state only.
interface min_feeder_if #(
  parameter int DATA_W = 16,
  parameter int NUM    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [NUM*DATA_W-1:0] min_numbers;
  logic                  min_start;
  logic [DATA_W-1:0]     min_result;
  logic                  min_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_min;
  logic                  out_err;

  modport master (
    input  in_valid, in_data, min_result, min_done, out_ready,
    output in_ready, min_numbers, min_start, out_valid, out_min, out_err
  );

  modport slave (
    output in_valid, in_data, min_result, min_done, out_ready,
    input  in_ready, min_numbers, min_start, out_valid, out_min, out_err
  );
endinterface

// File: rtl/min_feeder.sv
// Packs NUM score words into one vector, runs the external min-search unit on it
// under a watchdog, and hands the captured minimum downstream.
module min_feeder #(
  parameter int DATA_W  = 16,
  parameter int NUM     = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  min_feeder_if.master       bus,
  output logic [1:0]         state_dbg
);

  localparam int IDX_W = $clog2(NUM);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      wait_cnt;
  logic [NUM*DATA_W-1:0] numbers_q;
  logic [DATA_W-1:0]     out_min_q;
  logic                  out_err_q;

  logic accept;
  logic take_done;
  logic take_timeout;
  logic min_start_d;
  logic out_valid_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // min_done has priority over the watchdog when both land on the last RUN cycle.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    min_start_d  = 1'b0;
    out_valid_d  = 1'b0;
    case (state_q)
      FILL: begin
        accept = bus.in_valid && !rst;
        if (accept && (wr_idx == LAST_IDX)) state_d = RUN;
      end
      RUN: begin
        min_start_d = 1'b1;
        if (bus.min_done) begin
          take_done = 1'b1;
          state_d   = OUT;
        end else if (wait_cnt == LAST_CNT) begin
          take_timeout = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      wait_cnt  <= '0;
      numbers_q <= '0;
      out_min_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NUM; k++) begin
          if (wr_idx == IDX_W'(k)) numbers_q[k*DATA_W +: DATA_W] <= bus.in_data;
        end
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      if (state_q == RUN) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (take_done) begin
          out_min_q <= bus.min_result;
          out_err_q <= 1'b0;
          wait_cnt  <= '0;
        end else if (take_timeout) begin
          out_min_q <= '1;
          out_err_q <= 1'b1;
          wait_cnt  <= '0;
        end
      end
    end
  end

  // in_ready is gated by rst so it reads low during the reset cycle itself.
  assign bus.in_ready    = (state_q == FILL) && !rst;
  assign bus.min_start   = min_start_d;
  assign bus.out_valid   = out_valid_d;
  assign bus.min_numbers = numbers_q;
  assign bus.out_min     = out_min_q;
  assign bus.out_err     = out_err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_min_feeder.sv
// Directed bench for min_feeder: a behavioural search unit, a group-level model
// with expected queues, a per-cycle compare process and literal anchor checks.
module tb_min_feeder;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int TO = 16;
  localparam int VW = N * DW;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  min_feeder_if #(.DATA_W(DW), .NUM(N)) bus ();

  min_feeder #(.DATA_W(DW), .NUM(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // Search unit behaviour knobs.
  int su_lat   = 2;
  bit su_never = 1'b0;
  int su_cnt   = 0;

  // Model state: words of the group being filled, and per-group expectations.
  logic [DW-1:0] words[$];
  logic [VW-1:0] exp_vec_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_len_q[$];
  int            start_cnt = 0;

  logic [DW-1:0] g1[8] = '{16'h0300, 16'h0120, 16'h0500, 16'h0042, 16'h0777, 16'h0100, 16'h0999, 16'h0200};
  logic [DW-1:0] g2[8] = '{16'h1234, 16'h0000, 16'h5678, 16'h0001, 16'hFFFF, 16'h0100, 16'h8000, 16'h0020};
  logic [DW-1:0] g4[8] = '{16'h0700, 16'h0600, 16'h0050, 16'h0800, 16'h0900, 16'h0A00, 16'h0B00, 16'h0C00};
  logic [DW-1:0] g5[8] = '{16'h0500, 16'h0600, 16'h0700, 16'h0800, 16'h0900, 16'h0A00, 16'h0B00, 16'h0C00};
  logic [DW-1:0] g6[8] = '{16'h00A0, 16'h00B0, 16'h0011, 16'h00C0, 16'h00D0, 16'h00E0, 16'h00F0, 16'h0100};

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic record(input logic [DW-1:0] d);
    logic [VW-1:0] vec;
    logic [DW-1:0] mn;
    words.push_back(d);
    if (words.size() == N) begin
      vec = '0;
      mn  = words[0];
      for (int k = 0; k < N; k++) begin
        vec[k*DW +: DW] = words[k];
        if (words[k] < mn) mn = words[k];
      end
      exp_vec_q.push_back(vec);
      if (su_never || su_lat >= TO) begin
        exp_q.push_back({DW{1'b1}});
        exp_err_q.push_back(1'b1);
        exp_len_q.push_back(TO);
      end else begin
        exp_q.push_back(mn);
        exp_err_q.push_back(1'b0);
        exp_len_q.push_back(su_lat + 1);
      end
      words.delete();
    end
  endtask

  // Called from posedge+#1; returns at posedge+#1 after the word was taken.
  task automatic send_word(input logic [DW-1:0] d);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (got) record(d);
    else check("in_accept_timeout", 0, 1);
  endtask

  task automatic send_group(input logic [DW-1:0] g[8], input bit gapped);
    for (int k = 0; k < N; k++) begin
      send_word(g[k]);
      if (gapped) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out_valid();
    bit seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("out_valid_wait", seen, 1);
  endtask

  task automatic wait_groups_done();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("groups_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    words.delete();
  endtask

  // Behavioural search unit: done L cycles after start rises, held until start drops.
  initial begin
    bus.min_done   = 1'b0;
    bus.min_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.min_start) begin
        if (!su_never && su_cnt == su_lat) begin
          logic [DW-1:0] m;
          m = bus.min_numbers[DW-1:0];
          for (int k = 1; k < N; k++)
            if (bus.min_numbers[k*DW +: DW] < m) m = bus.min_numbers[k*DW +: DW];
          bus.min_result = m;
          bus.min_done   = 1'b1;
        end
        su_cnt++;
      end else begin
        su_cnt       = 0;
        bus.min_done = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("in_ready_in_reset", bus.in_ready, 0);
        start_cnt = 0;
      end else if (rst === 1'b0) begin
        check("in_ready_phase", bus.in_ready, !(bus.min_start || bus.out_valid));
        check("start_out_exclusive", bus.min_start && bus.out_valid, 0);
        if (bus.min_start) begin
          start_cnt++;
          if (exp_vec_q.size() == 0) check("unexpected_start", 1, 0);
          else check("min_numbers", bus.min_numbers, exp_vec_q[0]);
        end else if (start_cnt > 0) begin
          if (exp_len_q.size() != 0) check("start_len", start_cnt, exp_len_q[0]);
          start_cnt = 0;
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            check("out_min", bus.out_min, exp_q[0]);
            check("out_err", bus.out_err, exp_err_q[0]);
            if (bus.out_ready) begin
              void'(exp_vec_q.pop_front());
              void'(exp_q.pop_front());
              void'(exp_err_q.pop_front());
              void'(exp_len_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_min_start", bus.min_start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_min_numbers", bus.min_numbers, 0);
    check("rst_out_min", bus.out_min, 0);
    check("rst_out_err", bus.out_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back fill, real search unit.
    su_lat = 3;
    send_group(g1, 1'b0);
    @(negedge clk);
    check("g1_numbers_literal", bus.min_numbers, 128'h0200_0999_0100_0777_0042_0500_0120_0300);
    check("g1_start_literal", bus.min_start, 1);
    wait_out_valid();
    check("g1_min_literal", bus.out_min, 16'h0042);
    check("g1_err_literal", bus.out_err, 0);
    wait_groups_done();

    // Group with a zero word, done on the first RUN cycle.
    su_lat = 0;
    send_group(g2, 1'b0);
    wait_out_valid();
    check("g2_min_literal", bus.out_min, 16'h0000);
    wait_groups_done();

    // Stalled search unit: watchdog path.
    su_never = 1'b1;
    send_group(g1, 1'b0);
    wait_out_valid();
    check("timeout_min_literal", bus.out_min, 16'hFFFF);
    check("timeout_err_literal", bus.out_err, 1);
    wait_groups_done();
    su_never = 1'b0;

    // Gapped input and a 5-cycle downstream stall with the next word waiting.
    su_lat = 1;
    bus.out_ready = 1'b0;
    send_group(g4, 1'b1);
    wait_out_valid();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_min_literal", bus.out_min, 16'h0050);
    check("stall_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Partial group after the handshake, then reset, then a fresh group.
    for (int k = 1; k <= 5; k++) send_word(DW'(k));
    check("groups_before_reset", exp_q.size(), 0);
    do_reset();
    su_lat = 4;
    send_group(g5, 1'b0);
    @(negedge clk);
    check("fresh_numbers_literal", bus.min_numbers, 128'h0C00_0B00_0A00_0900_0800_0700_0600_0500);
    wait_out_valid();
    check("fresh_min_literal", bus.out_min, 16'h0500);
    wait_groups_done();

    // Done on the very cycle the watchdog would fire.
    su_lat = TO - 1;
    send_group(g6, 1'b0);
    wait_out_valid();
    check("coincide_min_literal", bus.out_min, 16'h0011);
    check("coincide_err_literal", bus.out_err, 0);
    wait_groups_done();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
